// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO burst read engine.
package fifo_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } rd_state_e;

    localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry FIFO-ordered skid buffer; an incoming word passes straight through when empty.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  valid,
    input  logic                  ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic                  head_q;
    logic [1:0]            count_q;
    logic                  pop;
    logic                  bypass;
    logic                  wr;
    logic                  tail;

    assign valid  = (count_q != 2'd0) | push;
    assign pop    = valid & ready;
    // Word arriving into an empty buffer and taken the same cycle is never stored.
    assign bypass = push & pop & (count_q == 2'd0);
    assign wr     = push & ~bypass;
    assign tail   = head_q ^ count_q[0];
    assign count  = count_q;

    always_comb begin
        data_out = '0;
        if (count_q != 2'd0) begin
            data_out = mem_q[head_q];
        end else if (push) begin
            data_out = data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= 1'b0;
            count_q <= 2'd0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr) begin
                mem_q[tail] <= data_in;
            end
            if (pop && count_q != 2'd0) begin
                head_q <= ~head_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Reads a commanded burst from the FIFO read port and streams it out with last/done framing.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    rd_state_e            state_q;
    logic [LEN_WIDTH-1:0] fetch_rem_q;
    logic [LEN_WIDTH-1:0] deliver_rem_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 inflight_q;
    logic [1:0]           buf_cnt;
    logic                 pop;
    logic [2:0]           occ;

    assign pop = m_valid & m_ready;
    // Occupancy after this cycle's pop; a new read may only be issued if a slot remains.
    assign occ = {1'b0, buf_cnt} + {2'b0, inflight_q} - {2'b0, pop};

    assign fifo_rd_en = (state_q == StRun) & ~fifo_empty & (fetch_rem_q != '0)
                      & (occ < 3'(SKID_DEPTH));

    assign m_last = m_valid & (deliver_rem_q == LEN_WIDTH'(1));
    assign busy   = busy_q;
    assign done   = done_q;

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk      (rd_clk),
        .rst_n    (rst_n),
        .push     (inflight_q),
        .data_in  (fifo_rd_data),
        .valid    (m_valid),
        .ready    (m_ready),
        .data_out (m_data),
        .count    (buf_cnt)
    );

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            fetch_rem_q   <= '0;
            deliver_rem_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            inflight_q    <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= fifo_rd_en;
            if (fifo_rd_en) begin
                fetch_rem_q <= fetch_rem_q - LEN_WIDTH'(1);
            end
            if (pop && deliver_rem_q != '0) begin
                deliver_rem_q <= deliver_rem_q - LEN_WIDTH'(1);
            end
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (burst_len != '0) begin
                            state_q       <= StRun;
                            fetch_rem_q   <= burst_len;
                            deliver_rem_q <= burst_len;
                            busy_q        <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (fifo_rd_en && fetch_rem_q == LEN_WIDTH'(1)) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (pop && deliver_rem_q == LEN_WIDTH'(1)) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench: cycle table for the basic burst, directed corner sequences, random bursts.
module tb_fifo_burst_reader;

    logic       rd_clk;
    logic       rst_n;
    logic       start;
    logic [7:0] burst_len;
    logic       fifo_empty = 1'b1;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       busy;
    logic       done;

    fifo_burst_reader #(
        .DATA_WIDTH (8),
        .LEN_WIDTH  (8)
    ) dut (
        .rd_clk       (rd_clk),
        .rst_n        (rst_n),
        .start        (start),
        .burst_len    (burst_len),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .busy         (busy),
        .done         (done)
    );

    initial begin
        rd_clk = 1'b0;
        forever #5 rd_clk = ~rd_clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIFO model: registered read data, writes become visible one edge after being posted.
    logic [7:0] fifo_q[$];
    logic [7:0] wr_pend[$];
    logic       flush_req = 1'b0;

    always @(posedge rd_clk) begin
        if (flush_req) begin
            fifo_q.delete();
        end else if (fifo_rd_en && fifo_q.size() > 0) begin
            fifo_rd_data <= fifo_q.pop_front();
        end
        while (wr_pend.size() > 0) fifo_q.push_back(wr_pend.pop_front());
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Reference: the stream must reproduce the FIFO's write order, burst_n words per burst.
    logic [7:0] exp_stream[$];
    int         burst_n   = 0;
    int         beat_base = 0;
    int         beats     = 0;
    int         rd_cnt    = 0;
    logic       mon_en    = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    task automatic fifo_write(input logic [7:0] w);
        wr_pend.push_back(w);
        exp_stream.push_back(w);
    endtask

    task automatic flush();
        flush_req = 1'b1;
        @(posedge rd_clk); #1;
        flush_req = 1'b0;
        exp_stream.delete();
    endtask

    always @(negedge rd_clk) begin
        if (!mon_en) begin
            stall_prev = 1'b0;
        end else begin
            if (fifo_rd_en) rd_cnt++;
            chk("rd_en_while_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
            chk("occupancy_le_2", 32'((32'(dut.buf_cnt) + 32'(dut.inflight_q)) <= 2), 32'd1);
            if (stall_prev) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", 32'(m_data), 32'(prev_data));
            end
            if (m_valid) begin
                chk("last_flag", 32'(m_last), 32'((beats - beat_base) == burst_n - 1));
            end else begin
                chk("last_without_valid", 32'(m_last), 32'd0);
            end
            if (m_valid && m_ready) begin
                if (exp_stream.size() == 0) begin
                    chk("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    chk("stream_data", 32'(m_data), 32'(exp_stream.pop_front()));
                end
                beats++;
            end
            stall_prev = m_valid & ~m_ready;
            prev_data  = m_data;
        end
    end

    task automatic preload(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) fifo_write(base + 8'(i));
        @(posedge rd_clk); #1;
    endtask

    function automatic logic rdy_of(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (c % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    // Cycle 0 drives start; done_cyc is the cycle (counted from start) at which done is seen.
    task automatic run_burst(input int len, input int rdy_mode, input int feed_n,
                             input int feed_at, input int feed_mode, input int restart_at,
                             input int restart_len, output int done_cyc);
        int rd_base;
        int feed_left;
        feed_left = feed_n;
        @(posedge rd_clk); #1;
        burst_n   = len;
        beat_base = beats;
        rd_base   = rd_cnt;
        start     = 1'b1;
        burst_len = 8'(len);
        m_ready   = rdy_of(rdy_mode, 0);
        @(negedge rd_clk);
        done_cyc = -1;
        for (int c = 1; c < 1200; c++) begin
            @(posedge rd_clk); #1;
            start = (c == restart_at);
            if (c == restart_at) burst_len = 8'(restart_len);
            m_ready = rdy_of(rdy_mode, c);
            if (feed_mode == 0 && c == feed_at) begin
                for (int i = 0; i < feed_left; i++) fifo_write(8'($urandom));
                feed_left = 0;
            end else if (feed_mode == 1 && feed_left > 0 && $urandom_range(0, 1) == 1) begin
                fifo_write(8'($urandom));
                feed_left--;
            end
            @(negedge rd_clk);
            if (done) begin
                done_cyc = c;
                chk("busy_drops_with_done", 32'(busy), 32'd0);
                break;
            end
            chk("busy_held", 32'(busy), 32'd1);
        end
        chk("done_seen", 32'(done_cyc > 0), 32'd1);
        chk("read_count", 32'(rd_cnt - rd_base), 32'(len));
        chk("beat_count", 32'(beats - beat_base), 32'(len));
        @(posedge rd_clk); #1;
        m_ready = 1'b1;
        @(negedge rd_clk);
        chk("done_single_pulse", 32'(done), 32'd0);
    endtask

    typedef struct {
        logic        st;
        logic [7:0]  len;
        logic [12:0] exp;  // {rd_en, valid, last, busy, done, data}
    } vec_t;

    vec_t vecs[11];
    int   dc;
    int   rbase;
    int   klen;
    int   kpre;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        burst_len = 8'd0;
        m_ready   = 1'b1;
        repeat (2) @(posedge rd_clk);
        @(negedge rd_clk);
        chk("reset_outputs", 32'({fifo_rd_en, m_valid, m_last, busy, done, m_data}), 32'd0);
        @(posedge rd_clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Basic 4-word burst followed by a zero-length start, one row per cycle.
        vecs[0]  = '{1'b1, 8'd4, {5'b00000, 8'h00}};
        vecs[1]  = '{1'b0, 8'd0, {5'b10010, 8'h00}};
        vecs[2]  = '{1'b0, 8'd0, {5'b11010, 8'h10}};
        vecs[3]  = '{1'b0, 8'd0, {5'b11010, 8'h11}};
        vecs[4]  = '{1'b0, 8'd0, {5'b11010, 8'h12}};
        vecs[5]  = '{1'b0, 8'd0, {5'b01110, 8'h13}};
        vecs[6]  = '{1'b0, 8'd0, {5'b00001, 8'h00}};
        vecs[7]  = '{1'b0, 8'd0, {5'b00000, 8'h00}};
        vecs[8]  = '{1'b1, 8'd0, {5'b00000, 8'h00}};
        vecs[9]  = '{1'b0, 8'd0, {5'b00001, 8'h00}};
        vecs[10] = '{1'b0, 8'd0, {5'b00000, 8'h00}};
        preload(4, 8'h10);
        burst_n   = 4;
        beat_base = beats;
        rbase     = rd_cnt;
        for (int i = 0; i < 11; i++) begin
            @(posedge rd_clk); #1;
            start     = vecs[i].st;
            burst_len = vecs[i].len;
            m_ready   = 1'b1;
            @(negedge rd_clk);
            chk($sformatf("vec%0d", i),
                32'({fifo_rd_en, m_valid, m_last, busy, done, m_data}), 32'(vecs[i].exp));
        end
        chk("basic_reads", 32'(rd_cnt - rbase), 32'd4);

        // Reset in the middle of a 4-word burst.
        preload(4, 8'h20);
        start = 1'b1; burst_len = 8'd4; burst_n = 4; beat_base = beats;
        @(posedge rd_clk); #1;
        start = 1'b0;
        @(posedge rd_clk); #1;
        @(negedge rd_clk);
        chk("pre_reset_valid", 32'(m_valid), 32'd1);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("async_reset_outputs",
            32'({fifo_rd_en, m_valid, m_last, busy, done, m_data}), 32'd0);
        repeat (2) @(posedge rd_clk);
        #1;
        rst_n = 1'b1;
        flush();
        mon_en = 1'b1;
        rbase  = rd_cnt;
        repeat (6) @(posedge rd_clk);
        #1;
        chk("no_read_after_reset", 32'(rd_cnt - rbase), 32'd0);

        // Backpressure with ready pattern 1,0,0,1,...
        preload(6, 8'h40);
        run_burst(6, 1, 0, 0, 0, -1, 0, dc);

        // Empty stall: two words up front, three more ten cycles later.
        preload(2, 8'h50);
        run_burst(5, 0, 3, 10, 0, -1, 0, dc);

        // Start pulse during a running burst must be ignored.
        preload(6, 8'h60);
        run_burst(3, 0, 0, 0, 0, 2, 5, dc);
        flush();

        // Maximum length with continuous data.
        preload(255, 8'h00);
        run_burst(255, 0, 0, 0, 0, -1, 0, dc);
        chk("max_done_cycle", 32'(dc), 32'd257);

        // Random bursts: random length, random ready, data dribbled in at random.
        for (int r = 0; r < 10; r++) begin
            klen = $urandom_range(1, 20);
            kpre = $urandom_range(0, klen);
            for (int i = 0; i < kpre; i++) fifo_write(8'($urandom));
            run_burst(klen, 2, klen - kpre, 0, 1, -1, 0, dc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
